sky130_fd_io__lvclamp_seq_ctrl: RTL

//  Power-up sequencer for a bank of low-voltage ESD clamp segments in the IO ring. Holds every clamp

---
 rtl/sky130_fd_io__lvclamp_seq_pkg.sv | 30 +++
 rtl/sky130_fd_io__lvclamp_seq_ctrl_if.sv | 29 ++
 rtl/sky130_fd_io__lvclamp_seq_dncnt.sv | 39 +++
 rtl/sky130_fd_io__lvclamp_seq_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sky130_fd_io__lvclamp_seq_pkg.sv
// Shared definitions for the low-voltage ESD clamp power-up sequencer.
//   - FSM state codes and the state enum (3 bits, also exported on seq_state)
//   - helpers for NSEG range checking and segment-index width
package sky130_fd_io__lvclamp_seq_pkg;

  localparam logic [2:0] SC_IDLE     = 3'd0;
  localparam logic [2:0] SC_DEBOUNCE = 3'd1;
  localparam logic [2:0] SC_RELEASE  = 3'd2;
  localparam logic [2:0] SC_RUN      = 3'd3;
  localparam logic [2:0] SC_FORCE    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = SC_IDLE,
    S_DEBOUNCE = SC_DEBOUNCE,
    S_RELEASE  = SC_RELEASE,
    S_RUN      = SC_RUN,
    S_FORCE    = SC_FORCE
  } seq_state_e;

  // Supported segment count is 1..16.
  function automatic bit seq_nseg_ok(input int n);
    return (n >= 1) && (n <= 16);
  endfunction

  // Segment index width; a single segment still gets a 1-bit index.
  function automatic int seq_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sky130_fd_io__lvclamp_seq_ctrl_if.sv
// Control/status bundle between the power-detect side and the clamp sequencer.
//   master : driver of supply-good, timing config and force request
//   slave  : the sequencer; returns clamp gate enables, force ack, done, state
interface sky130_fd_io__lvclamp_seq_ctrl_if #(
  parameter int NSEG  = 4,
  parameter int DB_W  = 8,
  parameter int STG_W = 6
);

  logic             pwr_good;
  logic [DB_W-1:0]  db_cycles;
  logic [STG_W-1:0] stg_cycles;
  logic             frc_req;
  logic             frc_ack;
  logic [NSEG-1:0]  clamp_on;
  logic             seq_done;
  logic [2:0]       seq_state;

  modport master (
    output pwr_good, db_cycles, stg_cycles, frc_req,
    input  frc_ack, clamp_on, seq_done, seq_state
  );

  modport slave (
    input  pwr_good, db_cycles, stg_cycles, frc_req,
    output frc_ack, clamp_on, seq_done, seq_state
  );

endinterface

// File: rtl/sky130_fd_io__lvclamp_seq_dncnt.sv
// Loadable down counter with zero flag.
//   clk, rst_n   : clock, synchronous active-low reset (count -> 0)
//   load_i       : load load_val_i (wins over dec_i)
//   load_val_i   : value to load
//   dec_i        : decrement by one; caller only asserts it while nonzero
//   zero_o       : count is zero
module sky130_fd_io__lvclamp_seq_dncnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sky130_fd_io__lvclamp_seq_ctrl.sv
// Power-up sequencer for a bank of low-voltage ESD clamp segments.
// Keeps all clamps shunting until pwr_good is debounced, then releases them
// one at a time on a programmable stagger; re-engages all at once on supply
// loss or a force request.
//   clk, rst_n : clock, synchronous active-low reset
//   seq_if     : slave side of the control/status bundle
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | clamps all on; waiting for pwr_good (force is acked here)
// DEBOUNCE | clamps all on; pwr_good must stay high for db_cycles
// RELEASE  | clearing clamp_on bits in ascending order, stagger apart
// RUN      | all clamps released, seq_done high
// FORCE    | clamps all on because of frc_req, frc_ack high
module sky130_fd_io__lvclamp_seq_ctrl
  import sky130_fd_io__lvclamp_seq_pkg::*;
#(
  parameter int NSEG  = 4,
  parameter int DB_W  = 8,
  parameter int STG_W = 6
) (
  input logic clk,
  input logic rst_n,
  sky130_fd_io__lvclamp_seq_ctrl_if.slave seq_if
);

  localparam int IDX_W = seq_idx_w(NSEG);

  if (!seq_nseg_ok(NSEG)) begin : g_nseg_range
    $error("NSEG must be in 1..16");
  end

  seq_state_e       state_q, state_d;
  logic [NSEG-1:0]  clamp_on_q, clamp_on_d;
  logic             seq_done_q, seq_done_d;
  logic             frc_ack_q, frc_ack_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             db_load, db_dec, db_zero;
  logic [DB_W-1:0]  db_load_val;
  logic             stg_load, stg_dec, stg_zero;
  logic [STG_W-1:0] stg_load_val;
  logic             arm_go;
  logic             rel_enter;
  logic             rel_clear;

  // The debounce counter holds db_cycles-1 so that RELEASE is entered
  // exactly db_cycles cycles after DEBOUNCE; db_cycles=0 bypasses it.
  sky130_fd_io__lvclamp_seq_dncnt #(.W(DB_W)) u_db_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (db_load),
    .load_val_i (db_load_val),
    .dec_i      (db_dec),
    .zero_o     (db_zero)
  );

  sky130_fd_io__lvclamp_seq_dncnt #(.W(STG_W)) u_stg_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (stg_load),
    .load_val_i (stg_load_val),
    .dec_i      (stg_dec),
    .zero_o     (stg_zero)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      clamp_on_q <= '1;
      seq_done_q <= 1'b0;
      frc_ack_q  <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      clamp_on_q <= clamp_on_d;
      seq_done_q <= seq_done_d;
      frc_ack_q  <= frc_ack_d;
      idx_q      <= idx_d;
    end
  end

  // Next state and counter control. Supply loss is checked first in every
  // active state so it beats both force and counter expiry.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    db_load      = 1'b0;
    db_dec       = 1'b0;
    db_load_val  = seq_if.db_cycles - DB_W'(1);
    stg_load     = 1'b0;
    stg_dec      = 1'b0;
    stg_load_val = '0;
    arm_go       = 1'b0;
    rel_enter    = 1'b0;
    rel_clear    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (seq_if.pwr_good && !seq_if.frc_req) begin
          arm_go = 1'b1;
        end
      end
      S_DEBOUNCE: begin
        if (!seq_if.pwr_good) begin
          state_d = S_IDLE;
        end else if (seq_if.frc_req) begin
          state_d = S_FORCE;
        end else if (db_zero) begin
          rel_enter = 1'b1;
        end else begin
          db_dec = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!seq_if.pwr_good) begin
          state_d = S_IDLE;
        end else if (seq_if.frc_req) begin
          state_d = S_FORCE;
        end else if (clamp_on_q == '0) begin
          state_d = S_RUN;
        end else if (stg_zero) begin
          rel_clear    = 1'b1;
          idx_d        = idx_q + IDX_W'(1);
          stg_load     = 1'b1;
          // gap of max(stg_cycles,1): reload with gap-1
          stg_load_val = (seq_if.stg_cycles == '0) ? '0 : seq_if.stg_cycles - STG_W'(1);
        end else begin
          stg_dec = 1'b1;
        end
      end
      S_RUN: begin
        if (!seq_if.pwr_good) begin
          state_d = S_IDLE;
        end else if (seq_if.frc_req) begin
          state_d = S_FORCE;
        end
      end
      S_FORCE: begin
        if (!seq_if.pwr_good) begin
          state_d = S_IDLE;
        end else if (!seq_if.frc_req) begin
          arm_go = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (arm_go) begin
      if (seq_if.db_cycles == '0) begin
        rel_enter = 1'b1;
      end else begin
        state_d = S_DEBOUNCE;
        db_load = 1'b1;
      end
    end

    // Stagger counter starts at zero so bit 0 clears on the first RELEASE cycle.
    if (rel_enter) begin
      state_d      = S_RELEASE;
      idx_d        = '0;
      stg_load     = 1'b1;
      stg_load_val = '0;
    end
  end

  // Registered-output next values, derived from the state being entered.
  always_comb begin
    clamp_on_d = clamp_on_q;
    seq_done_d = 1'b0;
    frc_ack_d  = 1'b0;

    unique case (state_d)
      S_IDLE: begin
        clamp_on_d = '1;
        frc_ack_d  = seq_if.frc_req;
      end
      S_DEBOUNCE: begin
        clamp_on_d = '1;
      end
      S_RELEASE: begin
        for (int i = 0; i < NSEG; i++) begin
          if (rel_clear && (idx_q == IDX_W'(i))) begin
            clamp_on_d[i] = 1'b0;
          end
        end
      end
      S_RUN: begin
        clamp_on_d = '0;
        seq_done_d = 1'b1;
      end
      S_FORCE: begin
        clamp_on_d = '1;
        frc_ack_d  = 1'b1;
      end
      default: clamp_on_d = '1;
    endcase
  end

  assign seq_if.clamp_on  = clamp_on_q;
  assign seq_if.seq_done  = seq_done_q;
  assign seq_if.frc_ack   = frc_ack_q;
  assign seq_if.seq_state = state_q;

endmodule
